// File: rtl/sumsq_acc_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sumsq_acc_fsm_pkg
// Description : float32 field constants and FSM state encoding shared by the
//               sum-of-squares accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package sumsq_acc_fsm_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] SAT_VAL = 32'h7F7F_FFFF;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ALIGN = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] ADD   = 3'd3;
    localparam logic [2:0] NORM  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = IDLE,
        ST_ALIGN = ALIGN,
        ST_SHIFT = SHIFT,
        ST_ADD   = ADD,
        ST_NORM  = NORM
    } state_t;

    function automatic logic [7:0] fp_exp(input logic [30:0] f);
        return f[EXP_MSB:EXP_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sumsq_acc_fsm_align_shift.sv
`default_nettype none
// ============================================================================
// Module      : fp32_align_shift
// Description : Combinational mantissa right-shifter; flushes to zero for a
//               zero operand or an exponent gap of 25 or more.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_align_shift (
    input  logic [23:0] i_mant,
    input  logic [7:0]  i_d,
    input  logic        i_zero,
    output logic [23:0] o_mant
);

    always_comb begin
        if (i_zero || (i_d >= 8'd25)) begin
            o_mant = '0;
        end else begin
            o_mant = i_mant >> i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sumsq_acc_fsm.sv
`default_nettype none
// ============================================================================
// Module      : sumsq_acc_fsm
// Description : Multi-cycle float32 accumulator (align/shift/add/normalize)
//               summing squared operands with truncation rounding.
// Revision    : 1.0 - initial release
// ============================================================================
module sumsq_acc_fsm
    import sumsq_acc_fsm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      x,
    input  logic             r_i,
    input  logic             err_i,
    input  logic             clr,
    output logic [31:0]      acc,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             r_o,
    output logic             err
);

    state_t             state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               r_o_q, r_o_d;
    logic               err_q, err_d;
    logic [30:0]        op_q, op_d;
    logic               inv_q, inv_d;
    logic [7:0]         ea_q, ea_d;
    logic [7:0]         dd_q, dd_d;
    logic [23:0]        ma_q, ma_d;
    logic [23:0]        mb_q, mb_d;
    logic               az_q, az_d;
    logic               bz_q, bz_d;
    logic [24:0]        sum_q, sum_d;

    logic [30:0]        w_fa, w_fb;
    logic [23:0]        w_mb_shift;
    logic [8:0]         w_exp9;
    logic [MAN_W-1:0]   w_man;

    fp32_align_shift u_shift (
        .i_mant (mb_q),
        .i_d    (dd_q),
        .i_zero (bz_q),
        .o_mant (w_mb_shift)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        r_o_d   = 1'b0;
        op_d    = op_q;
        inv_d   = inv_q;
        ea_d    = ea_q;
        dd_d    = dd_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        az_d    = az_q;
        bz_d    = bz_q;
        sum_d   = sum_q;
        w_fa    = acc_q[30:0];
        w_fb    = op_q;
        w_exp9  = sum_q[24] ? ({1'b0, ea_q} + 9'd1) : {1'b0, ea_q};
        w_man   = sum_q[24] ? sum_q[23:1] : sum_q[22:0];

        case (state_q)
            ST_IDLE: begin
                if (r_i) begin
                    op_d    = x[30:0];
                    inv_d   = err_i | x[SIGN_BIT];
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                // Ties keep the accumulator as the larger operand A.
                if (fp_exp(op_q) > fp_exp(acc_q[30:0])) begin
                    w_fa = op_q;
                    w_fb = acc_q[30:0];
                end
                ea_d    = fp_exp(w_fa);
                dd_d    = fp_exp(w_fa) - fp_exp(w_fb);
                az_d    = (fp_exp(w_fa) == 8'd0);
                bz_d    = (fp_exp(w_fb) == 8'd0);
                ma_d    = {fp_exp(w_fa) != 8'd0, w_fa[MAN_W-1:0]};
                mb_d    = {fp_exp(w_fb) != 8'd0, w_fb[MAN_W-1:0]};
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                mb_d    = w_mb_shift;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                sum_d   = {1'b0, ma_q} + {1'b0, mb_q};
                state_d = ST_NORM;
            end
            ST_NORM: begin
                state_d = ST_IDLE;
                if (inv_q) begin
                    err_d = 1'b1;
                end else if (az_q) begin
                    acc_d = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                    r_o_d = 1'b1;
                end else if (w_exp9 >= 9'(EXP_MAX)) begin
                    acc_d = SAT_VAL;
                    err_d = 1'b1;
                    r_o_d = 1'b1;
                end else begin
                    acc_d = {1'b0, w_exp9[7:0], w_man};
                    cnt_d = cnt_q + CNT_W'(1);
                    r_o_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An operand arriving mid-operation is lost; flag it and carry on.
        if (r_i && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end

        if (clr) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            r_o_d   = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            r_o_q   <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            inv_q   <= 1'b0;
            ea_q    <= '0;
            dd_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            az_q    <= 1'b0;
            bz_q    <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            r_o_q   <= r_o_d;
            err_q   <= err_d;
            op_q    <= op_d;
            inv_q   <= inv_d;
            ea_q    <= ea_d;
            dd_q    <= dd_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            az_q    <= az_d;
            bz_q    <= bz_d;
            sum_q   <= sum_d;
        end
    end

    assign acc  = acc_q;
    assign cnt  = cnt_q;
    assign busy = busy_q;
    assign r_o  = r_o_q;
    assign err  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sumsq_acc_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_sumsq_acc_fsm
// Description : Table-driven scoreboard bench for sumsq_acc_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sumsq_acc_fsm;

    localparam int CNT_W = 16;

    logic              clk = 1'b0;
    logic              rst, r_i, err_i, clr;
    logic [31:0]       x;
    logic [31:0]       acc;
    logic [CNT_W-1:0]  cnt;
    logic              busy, r_o, err;

    typedef struct {
        logic        clr_first;
        logic [31:0] x;
        logic [31:0] acc;
        logic [15:0] cnt;
        logic        err;
    } vec_t;

    typedef struct {
        logic [31:0] acc;
        logic [15:0] cnt;
        logic        err;
    } exp_t;

    vec_t tbl [12];
    exp_t sb [$];
    int   n_vec = 0;
    int   n_bad = 0;

    sumsq_acc_fsm #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .x     (x),
        .r_i   (r_i),
        .err_i (err_i),
        .clr   (clr),
        .acc   (acc),
        .cnt   (cnt),
        .busy  (busy),
        .r_o   (r_o),
        .err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic send(input logic [31:0] xv, input logic e);
        @(negedge clk);
        x     = xv;
        err_i = e;
        r_i   = 1'b1;
        @(negedge clk);
        r_i   = 1'b0;
        err_i = 1'b0;
    endtask

    // Waits for r_o; lat is the number of edges expected after the current point.
    task automatic await_result(input string name, input int lat);
        int   k;
        bit   seen;
        exp_t ex;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 12) begin
            @(posedge clk);
            #1;
            k++;
            if (r_o) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s timeout: no r_o within %0d cycles, want 1", name, k);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: unexpected r_o with empty scoreboard, want none", name);
        end else begin
            ex = sb.pop_front();
            check({name, " latency"}, k, lat);
            check({name, " acc"}, acc, ex.acc);
            check({name, " cnt"}, {16'd0, cnt}, {16'd0, ex.cnt});
            check({name, " err"}, {31'd0, err}, {31'd0, ex.err});
            @(posedge clk);
            #1;
            check({name, " r_o width"}, {31'd0, r_o}, 32'd0);
        end
    endtask

    task automatic idle_watch(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (r_o) hits++;
        end
    endtask

    initial begin
        int hits;

        tbl[0]  = '{1'b1, 32'h3F80_0000, 32'h3F80_0000, 16'd1, 1'b0};
        tbl[1]  = '{1'b0, 32'h4000_0000, 32'h4040_0000, 16'd2, 1'b0};
        tbl[2]  = '{1'b1, 32'h4110_0000, 32'h4110_0000, 16'd1, 1'b0};
        tbl[3]  = '{1'b0, 32'h4080_0000, 32'h4150_0000, 16'd2, 1'b0};
        tbl[4]  = '{1'b1, 32'h4080_0000, 32'h4080_0000, 16'd1, 1'b0};
        tbl[5]  = '{1'b0, 32'h3E80_0000, 32'h4088_0000, 16'd2, 1'b0};
        tbl[6]  = '{1'b1, 32'h3F80_0000, 32'h3F80_0000, 16'd1, 1'b0};
        tbl[7]  = '{1'b0, 32'h3080_0000, 32'h3F80_0000, 16'd2, 1'b0};
        tbl[8]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 16'd1, 1'b0};
        tbl[9]  = '{1'b0, 32'h3F80_0000, 32'h3F80_0000, 16'd2, 1'b0};
        tbl[10] = '{1'b1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 16'd1, 1'b0};
        tbl[11] = '{1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 16'd1, 1'b1};

        rst = 1'b1; r_i = 1'b0; err_i = 1'b0; clr = 1'b0; x = '0;
        repeat (3) @(negedge clk);
        check("reset acc", acc, 32'd0);
        check("reset cnt", {16'd0, cnt}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset r_o", {31'd0, r_o}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].clr_first) pulse_clr();
            send(tbl[i].x, 1'b0);
            check($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd1);
            sb.push_back('{tbl[i].acc, tbl[i].cnt, tbl[i].err});
            await_result($sformatf("vec%0d", i), 4);
        end

        pulse_clr();
        check("clr acc", acc, 32'd0);
        check("clr cnt", {16'd0, cnt}, 32'd0);
        check("clr err", {31'd0, err}, 32'd0);

        // Upstream error flag: operand ignored, err set, no r_o.
        send(32'h3F80_0000, 1'b0);
        sb.push_back('{32'h3F80_0000, 16'd1, 1'b0});
        await_result("pre_err_i", 4);
        send(32'h4000_0000, 1'b1);
        idle_watch(8, hits);
        check("err_i r_o count", hits, 32'd0);
        check("err_i acc", acc, 32'h3F80_0000);
        check("err_i cnt", {16'd0, cnt}, 32'd1);
        check("err_i err", {31'd0, err}, 32'd1);

        // Negative operand.
        pulse_clr();
        send(32'hBF80_0000, 1'b0);
        idle_watch(8, hits);
        check("neg r_o count", hits, 32'd0);
        check("neg acc", acc, 32'd0);
        check("neg cnt", {16'd0, cnt}, 32'd0);
        check("neg err", {31'd0, err}, 32'd1);

        // Second operand two cycles after an accepted one is dropped.
        pulse_clr();
        @(negedge clk);
        x = 32'h3F80_0000; r_i = 1'b1;
        @(negedge clk);
        r_i = 1'b0;
        @(negedge clk);
        x = 32'h4000_0000; r_i = 1'b1;
        @(negedge clk);
        r_i = 1'b0;
        check("drop err early", {31'd0, err}, 32'd1);
        sb.push_back('{32'h3F80_0000, 16'd1, 1'b1});
        await_result("drop", 2);
        idle_watch(6, hits);
        check("drop extra r_o", hits, 32'd0);
        check("drop cnt after", {16'd0, cnt}, 32'd1);

        // clr during SHIFT aborts the add.
        pulse_clr();
        send(32'h3F80_0000, 1'b0);
        sb.push_back('{32'h3F80_0000, 16'd1, 1'b0});
        await_result("pre_abort_clr", 4);
        send(32'h4000_0000, 1'b0);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort clr busy", {31'd0, busy}, 32'd0);
        check("abort clr acc", acc, 32'd0);
        check("abort clr cnt", {16'd0, cnt}, 32'd0);
        idle_watch(6, hits);
        check("abort clr r_o", hits, 32'd0);

        // rst during SHIFT aborts the add.
        send(32'h3F80_0000, 1'b0);
        sb.push_back('{32'h3F80_0000, 16'd1, 1'b0});
        await_result("pre_abort_rst", 4);
        send(32'h4000_0000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort rst busy", {31'd0, busy}, 32'd0);
        check("abort rst acc", acc, 32'd0);
        check("abort rst cnt", {16'd0, cnt}, 32'd0);
        idle_watch(6, hits);
        check("abort rst r_o", hits, 32'd0);

        send(32'h4110_0000, 1'b0);
        sb.push_back('{32'h4110_0000, 16'd1, 1'b0});
        await_result("recover", 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
